// File: rtl/memory_lsu.sv
// RV32I MEMORY-stage load/store unit driving a pipelined Wishbone B4 master; rsp one cycle after ack/err.
// Backpressure: req_ready only in IDLE, wb_stall holds the strobe phase, flush aborts without a response.
module memory_lsu #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wr_data,
   input  logic                  flush,
   output logic                  busy,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_load_data,
   output logic                  rsp_err_align,
   output logic                  rsp_err_bus,
   output logic                  rsp_err_timeout,
   output logic                  wb_cyc,
   output logic                  wb_stb,
   output logic                  wb_we,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   output logic [31:0]           wb_wr_data,
   output logic [3:0]            wb_sel,
   input  logic                  wb_ack,
   input  logic                  wb_err,
   input  logic                  wb_stall,
   input  logic [31:0]           wb_rd_data
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} state_t;

   state_t          state, state_nxt;
   logic            accept, dec_ok;
   logic [3:0]      dec_sel;
   logic [31:0]     dec_wdata;
   logic            we_q;
   logic [2:0]      f3_q;
   logic [1:0]      off_q;
   logic [CW-1:0]   tcnt;
   logic            tmo_hit;
   logic            fin_ack, fin_bus, fin_tmo, fin_align;
   logic [31:0]     shifted, ld_ext;

   assign req_ready = (state == S_IDLE);
   assign busy      = ~req_ready;
   assign wb_cyc    = (state == S_REQ) || (state == S_WAIT);
   assign wb_stb    = (state == S_REQ);
   assign wb_we     = we_q & wb_cyc;
   assign accept    = req_ready & req_valid & ~flush;
   assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tcnt >= T_LAST);

   always_comb begin
      dec_ok    = 1'b0;
      dec_sel   = 4'b0000;
      dec_wdata = req_wr_data;
      case (req_funct3)
         3'b000, 3'b100: begin
            dec_ok    = 1'b1;
            dec_sel   = 4'b0001 << req_addr[1:0];
            dec_wdata = {4{req_wr_data[7:0]}};
         end
         3'b001, 3'b101: begin
            dec_ok    = ~req_addr[0];
            dec_sel   = req_addr[1] ? 4'b1100 : 4'b0011;
            dec_wdata = {2{req_wr_data[15:0]}};
         end
         3'b010: begin
            dec_ok  = (req_addr[1:0] == 2'b00);
            dec_sel = 4'b1111;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Completion priority: flush, then bus error, then ack, then timeout.
   always_comb begin
      state_nxt = state;
      fin_ack   = 1'b0;
      fin_bus   = 1'b0;
      fin_tmo   = 1'b0;
      fin_align = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = dec_ok ? S_REQ : S_ERR;
         end
         S_REQ, S_WAIT: begin
            if (wb_err) begin
               fin_bus   = 1'b1;
               state_nxt = S_IDLE;
            end else if (wb_ack) begin
               fin_ack   = 1'b1;
               state_nxt = S_IDLE;
            end else if (tmo_hit) begin
               fin_tmo   = 1'b1;
               state_nxt = S_IDLE;
            end else if (state == S_REQ && !wb_stall) begin
               state_nxt = S_WAIT;
            end
         end
         S_ERR: begin
            fin_align = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (flush) begin
         state_nxt = S_IDLE;
         fin_ack   = 1'b0;
         fin_bus   = 1'b0;
         fin_tmo   = 1'b0;
         fin_align = 1'b0;
      end
   end

   // Halfword offsets are only ever 0 or 2 here, so one shift serves all widths.
   always_comb begin
      shifted = wb_rd_data >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  ld_ext = {24'b0, shifted[7:0]};
         3'b001:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  ld_ext = {16'b0, shifted[15:0]};
         default: ld_ext = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_addr         <= '0;
         wb_sel          <= '0;
         wb_wr_data      <= '0;
         we_q            <= 1'b0;
         f3_q            <= '0;
         off_q           <= '0;
         tcnt            <= '0;
         rsp_valid       <= 1'b0;
         rsp_load_data   <= '0;
         rsp_err_align   <= 1'b0;
         rsp_err_bus     <= 1'b0;
         rsp_err_timeout <= 1'b0;
      end else begin
         rsp_valid       <= fin_ack | fin_bus | fin_tmo | fin_align;
         rsp_err_align   <= fin_align;
         rsp_err_bus     <= fin_bus;
         rsp_err_timeout <= fin_tmo;
         rsp_load_data   <= (fin_ack && !we_q) ? ld_ext : '0;
         if (accept) begin
            wb_addr    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            wb_sel     <= dec_sel;
            wb_wr_data <= dec_wdata;
            we_q       <= req_store;
            f3_q       <= req_funct3;
            off_q      <= req_addr[1:0];
         end
         if (state == S_REQ || state == S_WAIT) begin
            if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;
         end else begin
            tcnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_memory_lsu.sv
// Randomised scoreboard bench for memory_lsu, plus a short-timeout instance for the timeout path.
module tb_memory_lsu;

   logic        clk, rst;
   logic        req_valid, req_store, flush;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wr_data;
   logic        req_ready, busy, rsp_valid, rsp_err_align, rsp_err_bus, rsp_err_timeout;
   logic [31:0] rsp_load_data;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_addr, wb_wr_data;
   logic [3:0]  wb_sel;
   logic        wb_ack, wb_err, wb_stall;
   logic [31:0] wb_rd_data;

   logic        t_req_valid, t_req_ready, t_busy, t_rsp_valid;
   logic        t_err_align, t_err_bus, t_err_timeout;
   logic [31:0] t_rsp_data, t_wb_addr, t_wb_wr_data;
   logic        t_wb_cyc, t_wb_stb, t_wb_we;
   logic [3:0]  t_wb_sel;
   logic        t_zero;
   logic [31:0] t_zero32;

   memory_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wr_data(req_wr_data), .flush(flush), .busy(busy), .rsp_valid(rsp_valid),
      .rsp_load_data(rsp_load_data), .rsp_err_align(rsp_err_align),
      .rsp_err_bus(rsp_err_bus), .rsp_err_timeout(rsp_err_timeout),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_wr_data(wb_wr_data), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err),
      .wb_stall(wb_stall), .wb_rd_data(wb_rd_data)
   );

   memory_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut_t (
      .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wr_data(req_wr_data), .flush(t_zero), .busy(t_busy), .rsp_valid(t_rsp_valid),
      .rsp_load_data(t_rsp_data), .rsp_err_align(t_err_align),
      .rsp_err_bus(t_err_bus), .rsp_err_timeout(t_err_timeout),
      .wb_cyc(t_wb_cyc), .wb_stb(t_wb_stb), .wb_we(t_wb_we), .wb_addr(t_wb_addr),
      .wb_wr_data(t_wb_wr_data), .wb_sel(t_wb_sel), .wb_ack(t_zero), .wb_err(t_zero),
      .wb_stall(t_zero), .wb_rd_data(t_zero32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   typedef struct { int cyc; logic [31:0] data; logic [2:0] err; } exp_rsp_t;  // err = {align,bus,timeout}
   typedef struct { logic [31:0] addr; logic [3:0] sel; logic [31:0] wdata; logic we; } exp_bus_t;

   exp_rsp_t exp_q[$];
   exp_bus_t bus_q[$];
   int checks = 0;
   int passed = 0;

   // Slave behaviour for the next bus cycle: kind 0 ack, 1 err, 2 silent, 3 ack+err.
   int          sl_s, sl_d, sl_kind;
   logic [31:0] sl_rdata;
   logic        slave_busy;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      else passed++;
   endtask

   function automatic logic [31:0] model_load(input logic [2:0] f3, input int o, input logic [31:0] rd);
      logic [31:0] v;
      case (f3)
         3'd0, 3'd4: begin
            v = (rd >> (8 * o)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
         end
         3'd1, 3'd5: begin
            v = (rd >> (8 * o)) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
         end
         default: v = rd;
      endcase
      return v;
   endfunction

   // Response monitor.
   initial begin
      exp_rsp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_rsp: actual rsp_valid=1 at cycle %0d, required no response", cyc_cnt);
            end else begin
               e = exp_q.pop_front();
               chk("rsp", {32'(cyc_cnt), rsp_load_data, 29'd0, rsp_err_align, rsp_err_bus, rsp_err_timeout},
                          {32'(e.cyc), e.data, 29'd0, e.err});
            end
         end
      end
   end

   // Wishbone slave model.
   initial begin
      exp_bus_t b;
      wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_rd_data = '0; slave_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (wb_stb && !slave_busy) begin
            slave_busy = 1'b1;
            if (bus_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_bus: actual stb addr %0h, required no bus cycle", wb_addr);
            end else begin
               b = bus_q.pop_front();
               chk("bus_fields", {wb_addr, 28'd0, wb_sel, wb_wr_data, 31'd0, wb_we},
                                 {b.addr, 28'd0, b.sel, b.wdata, 31'd0, b.we});
            end
            for (int j = 0; j <= sl_s; j++) begin
               if (j > 0) @(negedge clk);
               chk("stb_hold", {wb_stb, wb_cyc}, 2'b11);
               wb_stall = (j < sl_s);
            end
            @(negedge clk);
            chk("stb_drop", wb_stb, 1'b0);
            repeat (sl_d - 1) @(negedge clk);
            wb_ack     = (sl_kind == 0 || sl_kind == 3);
            wb_err     = (sl_kind == 1 || sl_kind == 3);
            wb_rd_data = sl_rdata;
            @(negedge clk);
            wb_ack     = 1'b0;
            wb_err     = 1'b0;
            wb_rd_data = $urandom;
            slave_busy = 1'b0;
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!(req_ready && !slave_busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         $display("FAIL wait_ready: actual never ready, required ready within 300 cycles");
      end
   endtask

   // mode 0 normal, 1 flush k cycles after accept, 2 reset mid-REQ. Entered and left at a negedge.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int s, input int d, input int kind,
                        input int mode_in, input int k);
      logic     legal;
      int       sz, o, e_cyc, mode;
      exp_bus_t b;
      exp_rsp_t e;
      wait_ready();
      o = int'(a[1:0]);
      case (f3)
         3'd0, 3'd4: begin legal = 1'b1;    sz = 1; end
         3'd1, 3'd5: begin legal = (o % 2 == 0); sz = 2; end
         3'd2:       begin legal = (o == 0); sz = 4; end
         default:    begin legal = 1'b0;    sz = 4; end
      endcase
      mode = legal ? mode_in : 0;
      if (legal) begin
         b.addr  = a & ~32'h3;
         b.sel   = 4'(((1 << sz) - 1) << o);
         b.wdata = (sz == 1) ? {24'd0, wd[7:0]} * 32'h01010101 :
                   (sz == 2) ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
         b.we    = st;
         bus_q.push_back(b);
      end
      sl_s = s; sl_d = d; sl_kind = kind; sl_rdata = rd;
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wr_data = wd;
      @(posedge clk);
      #1;
      e_cyc = cyc_cnt;
      req_valid = 1'b0;
      if (!legal) begin
         e.cyc = e_cyc + 1; e.data = '0; e.err = 3'b100;
         exp_q.push_back(e);
      end else if (mode == 0) begin
         if (kind == 2) begin
            e.cyc = e_cyc + 64; e.data = '0; e.err = 3'b001;
         end else if (kind == 0) begin
            e.cyc = e_cyc + 1 + s + d; e.data = st ? 32'd0 : model_load(f3, o, rd); e.err = 3'b000;
         end else begin
            e.cyc = e_cyc + 1 + s + d; e.data = '0; e.err = 3'b010;
         end
         exp_q.push_back(e);
      end
      if (mode == 1) begin
         repeat (k + 1) @(negedge clk);
         flush = 1'b1;
         @(negedge clk);
         flush = 1'b0;
         chk("flush_abort", {wb_cyc, wb_stb, req_ready}, 3'b001);
      end else if (mode == 2) begin
         repeat (2) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         chk("rst_mid", {wb_cyc, wb_stb, wb_we, req_ready, busy, rsp_valid, wb_sel, wb_addr},
                        {3'b000, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0});
         rst = 1'b0;
      end else begin
         @(negedge clk);
      end
   endtask

   initial begin
      int          n, e_cyc, n_cyc, rsp_at;
      logic [2:0]  t_flags;
      logic [31:0] t_data;
      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0;
      req_wr_data = '0; flush = 1'b0; t_req_valid = 1'b0; t_zero = 1'b0; t_zero32 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset", {req_ready, busy, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err_align, rsp_err_bus,
                    rsp_err_timeout, wb_sel, wb_addr, rsp_load_data, t_req_ready, t_wb_cyc},
                   {1'b1, 8'd0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0});

      issue(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0, 0, 0);       // LW zero-wait
      issue(1'b0, 3'd0, 32'h103, 32'h0, 32'h80123456, 0, 1, 0, 0, 0);       // LB sign
      issue(1'b0, 3'd4, 32'h103, 32'h0, 32'h80123456, 0, 1, 0, 0, 0);       // LBU
      issue(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 3, 1, 0, 0, 0);       // SH stalled
      issue(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1, 0, 0, 0);              // misaligned LW
      issue(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1, 0, 0, 0);              // illegal funct3
      issue(1'b0, 3'd2, 32'h200, 32'h0, 32'h11, 1, 2, 1, 0, 0);             // wb_err
      issue(1'b0, 3'd5, 32'h202, 32'h0, 32'h9ABC0000, 0, 1, 3, 0, 0);       // ack+err: err wins
      issue(1'b0, 3'd2, 32'h300, 32'h0, 32'h55, 0, 20, 0, 1, 3);            // flush in WAIT, late ack
      issue(1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1, 5, 2, 2, 0);              // reset mid-REQ
      issue(1'b0, 3'd1, 32'h402, 32'h0, 32'h8001FFFF, 2, 3, 0, 0, 0);       // LH upper half
      issue(1'b0, 3'd2, 32'h500, 32'h0, 32'h0, 0, 1, 2, 0, 0);              // default timeout

      wait_ready();
      req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'd2; req_addr = 32'h700; req_store = 1'b0;
      @(negedge clk);
      chk("flush_idle", {busy, wb_cyc}, 2'b00);
      req_valid = 1'b0; flush = 1'b0;

      for (int i = 0; i < 150; i++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         int          s, d, kind, mode, k, r;
         if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
         else begin
            r = $urandom_range(0, 4);
            f3 = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : (r == 2) ? 3'd2 : (r == 3) ? 3'd4 : 3'd5;
         end
         a = $urandom;
         if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
         s = $urandom_range(0, 3);
         d = $urandom_range(1, 4);
         r = $urandom_range(0, 9);
         kind = (r < 7) ? 0 : (r < 9) ? 1 : 3;
         mode = 0; k = 0;
         if ($urandom_range(0, 9) == 0) begin
            mode = 1; d = 20; kind = ($urandom_range(0, 1) == 0) ? 0 : 2;
            k = s + 1 + $urandom_range(0, 4);
         end
         issue(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom, s, d, kind, mode, k);
      end

      wait_ready();
      req_funct3 = 3'd2; req_addr = 32'h600; req_store = 1'b0;
      t_req_valid = 1'b1;
      @(posedge clk);
      #1;
      e_cyc = cyc_cnt;
      t_req_valid = 1'b0;
      n_cyc = 0; rsp_at = -1; t_flags = 3'b000; t_data = 32'hFFFFFFFF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (t_wb_cyc) n_cyc++;
         if (t_rsp_valid) begin
            rsp_at  = cyc_cnt;
            t_flags = {t_err_align, t_err_bus, t_err_timeout};
            t_data  = t_rsp_data;
         end
      end
      chk("tmo_cyc_len", 32'(n_cyc), 32'd4);
      chk("tmo_rsp", {32'(rsp_at), 29'd0, t_flags, t_data}, {32'(e_cyc + 4), 29'd0, 3'b001, 32'h0});

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      chk("bus_drain", 32'(bus_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
